// File: rtl/video_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_rx : serial video RAM receiver feeding a 16x16 pixel buffer.   |
// | Option   : VIDEO_RX_DOUBLE_BUFFER_EN selects front/back buffering.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module video_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        video_clk,
  input  logic        video_out,
  input  logic        video_sync,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        frame_done,
  output logic        frame_error,
  output logic        locked
);

  typedef enum logic [1:0] {
    ST_SEEK = 2'd0,
    ST_GAP  = 2'd1,
    ST_RECV = 2'd2,
    ST_WRAP = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] vclk_sync_q;
  logic [SYNC_STAGES-1:0] vout_sync_q;
  logic [SYNC_STAGES-1:0] vsync_sync_q;
  logic                   vclk_prev_q;

  logic strobe;
  logic pix_s;
  logic sync_s;

  state_e      state_q;
  logic [7:0]  idx_q;
  logic [15:0] row_q;
  logic [15:0] row_d;
  logic        locked_q;
  logic        done_set_q;
  logic        err_set_q;
  logic        frame_done_q;
  logic        frame_error_q;
  logic [15:0] rd_data_q;
  logic [15:0] rd_data_d;

  logic       capture;
  logic       wr_en;
  logic [3:0] wr_row;
  logic       commit;
  logic       frame_bad;

  // Clock chain resets high so a video_clk already high at reset release
  // does not look like a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vclk_sync_q  <= '1;
      vout_sync_q  <= '0;
      vsync_sync_q <= '0;
      vclk_prev_q  <= 1'b1;
    end else begin
      vclk_sync_q  <= {vclk_sync_q[SYNC_STAGES-2:0], video_clk};
      vout_sync_q  <= {vout_sync_q[SYNC_STAGES-2:0], video_out};
      vsync_sync_q <= {vsync_sync_q[SYNC_STAGES-2:0], video_sync};
      vclk_prev_q  <= vclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe = vclk_sync_q[SYNC_STAGES-1] & ~vclk_prev_q;
  assign pix_s  = vout_sync_q[SYNC_STAGES-1];
  assign sync_s = vsync_sync_q[SYNC_STAGES-1];

  always_comb begin
    row_d                = row_q;
    row_d[idx_q[3:0]]    = pix_s;
  end

  // A sync before the last pixel aborts the frame without capturing.
  assign capture   = strobe && (state_q == ST_RECV) && (!sync_s || (idx_q == 8'hFF));
  assign wr_en     = capture && (idx_q[3:0] == 4'hF);
  assign wr_row    = idx_q[7:4];
  assign commit    = capture && sync_s;
  assign frame_bad = strobe && (((state_q == ST_RECV) && sync_s && (idx_q != 8'hFF)) ||
                                (state_q == ST_WRAP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SEEK;
      idx_q         <= '0;
      row_q         <= '0;
      locked_q      <= 1'b0;
      done_set_q    <= 1'b0;
      err_set_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      done_set_q    <= commit;
      err_set_q     <= frame_bad;
      frame_done_q  <= done_set_q;
      frame_error_q <= err_set_q;
      if (capture) begin
        row_q <= row_d;
      end
      if (strobe) begin
        case (state_q)
          ST_SEEK: begin
            if (sync_s) begin
              state_q  <= ST_GAP;
              locked_q <= 1'b1;
            end
          end
          ST_GAP: begin
            state_q <= ST_RECV;
            idx_q   <= '0;
          end
          ST_RECV: begin
            if (sync_s) begin
              state_q <= ST_GAP;
            end else if (idx_q == 8'hFF) begin
              state_q  <= ST_WRAP;
              locked_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 8'd1;
            end
          end
          ST_WRAP: begin
            state_q  <= sync_s ? ST_GAP : ST_SEEK;
            locked_q <= sync_s;
          end
          default: begin
            state_q  <= ST_SEEK;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef VIDEO_RX_DOUBLE_BUFFER_EN
  logic [15:0] buf0_q [16];
  logic [15:0] buf1_q [16];
  logic        sel_q;
  logic        sel_d;

  // sel_q = 0: buf0 is displayed, buf1 collects the incoming frame.
  assign sel_d = sel_q ^ commit;

  always_comb begin
    rd_data_d = sel_d ? buf1_q[rd_addr] : buf0_q[rd_addr];
    if (commit && (wr_row == rd_addr)) begin
      rd_data_d = row_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_q    <= '{default: '0};
      buf1_q    <= '{default: '0};
      sel_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (wr_en && sel_q) begin
        buf0_q[wr_row] <= row_d;
      end
      if (wr_en && !sel_q) begin
        buf1_q[wr_row] <= row_d;
      end
      sel_q     <= sel_d;
      rd_data_q <= rd_data_d;
    end
  end
`else
  logic [15:0] buf_q [16];

  always_comb begin
    rd_data_d = buf_q[rd_addr];
    if (wr_en && (wr_row == rd_addr)) begin
      rd_data_d = row_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q     <= '{default: '0};
      rd_data_q <= '0;
    end else begin
      if (wr_en) begin
        buf_q[wr_row] <= row_d;
      end
      rd_data_q <= rd_data_d;
    end
  end
`endif

  assign rd_data     = rd_data_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign locked      = locked_q;

endmodule
`default_nettype wire
